// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, optional two-entry
// skid buffer, synchronous flush that leaves a bubble, zeroed control bits on
// bubbles and a saturating bubble counter for performance monitoring.
module pipe_stage_elastic #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state;
  logic              in_ready_q;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [TAG_W-1:0]  skid_tag;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              drain;

  // Handshake qualifiers; with no skid entry, ready follows the downstream side
  assign in_ready = (SKID != 0) ? in_ready_q : (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  // Stage FSM with registered outputs; main register drives the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      in_ready_q <= 1'b1;
      occupancy  <= 2'd0;
      out_ctrl   <= '0;
      out_tag    <= '0;
      out_data   <= '0;
      skid_ctrl  <= '0;
      skid_tag   <= '0;
      skid_data  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_ready && !out_valid && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
      if (flush) begin
        // Kill everything held plus the current input; tag/data keep last value
        state      <= EMPTY;
        out_valid  <= 1'b0;
        in_ready_q <= 1'b1;
        occupancy  <= 2'd0;
        out_ctrl   <= '0;
      end else begin
        unique case (state)
          EMPTY: begin
            if (accept) begin
              state      <= ONE;
              out_valid  <= 1'b1;
              in_ready_q <= 1'b1;
              occupancy  <= 2'd1;
              out_ctrl   <= in_ctrl;
              out_tag    <= in_tag;
              out_data   <= in_data;
            end
          end
          ONE: begin
            if (accept && drain) begin
              out_ctrl <= in_ctrl;
              out_tag  <= in_tag;
              out_data <= in_data;
            end else if (accept && (SKID != 0)) begin
              // Downstream stalled: park the new entry behind main
              state      <= FULL;
              in_ready_q <= 1'b0;
              occupancy  <= 2'd2;
              skid_ctrl  <= in_ctrl;
              skid_tag   <= in_tag;
              skid_data  <= in_data;
            end else if (drain) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
              occupancy <= 2'd0;
              out_ctrl  <= '0;
            end
          end
          FULL: begin
            if (drain) begin
              state      <= ONE;
              in_ready_q <= 1'b1;
              occupancy  <= 2'd1;
              out_ctrl   <= skid_ctrl;
              out_tag    <= skid_tag;
              out_data   <= skid_data;
            end
          end
          default: begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            in_ready_q <= 1'b1;
            occupancy  <= 2'd0;
            out_ctrl   <= '0;
          end
        endcase
      end
    end
  end

endmodule
